// File: rtl/ram_loader_if.sv
// Byte-stream and RAM write-port bundle for ram_loader.
// The loader side uses the slave modport; the byte source / RAM side uses the master modport.
interface ram_loader_if #(
    parameter int ADDR_W = 5
) ();
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic              mem_we;
    logic [3:0]        mem_sel;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words;

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, mem_addr, mem_din, mem_we, mem_sel,
        output cpu_hold, done, err, words
    );

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, mem_addr, mem_din, mem_we, mem_sel,
        input  cpu_hold, done, err, words
    );
endinterface

// File: rtl/ram_loader.sv
// Debug loader: framed byte stream -> little-endian 32-bit word writes into the data RAM.
// Optional trailing XOR checksum and sticky err flag when LOADER_CHECKSUM_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for HEADER, other bytes dropped
// S_ADDR  | taking start word address
// S_COUNT | taking word count N
// S_DATA  | assembling a word, byte index 0..3
// S_WRITE | one-cycle RAM write of the assembled word, byte input stalled
// S_CHECK | taking checksum byte (checksum build only)
// S_DONE  | one-cycle done pulse, releases cpu_hold
module ram_loader #(
    parameter int         ADDR_W = 5,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    ram_loader_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_COUNT = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK = 3'd5,
`endif
        S_DONE  = 3'd6
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CHECK;
`else
    localparam state_t S_END = S_DONE;
`endif

    localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       sh_q, sh_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        rem_q, rem_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              hold_q, hold_d;
    logic              rx_ready, take, mem_we, done;
`ifdef LOADER_CHECKSUM_EN
    logic              err_q, err_d;
    logic [7:0]        xor_q, xor_d;
`endif

    assign rx_ready = (state_q != S_WRITE) && (state_q != S_DONE);
    assign take     = bus.rx_valid & rx_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        words_d = words_q;
        hold_d  = hold_q;
        mem_we  = 1'b0;
        done    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        err_d   = err_q;
        xor_d   = xor_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (take && bus.rx_data == HEADER) begin
                    state_d = S_ADDR;
                    words_d = '0;
                    hold_d  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    err_d   = 1'b0;
                    xor_d   = 8'h00;
`endif
                end
            end
            S_ADDR: begin
                if (take) begin
                    addr_d  = ADDR_W'(bus.rx_data);
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (take) begin
                    rem_d   = bus.rx_data;
                    idx_d   = 2'd0;
                    state_d = (bus.rx_data != 8'h00) ? S_DATA : S_END;
                end
            end
            S_DATA: begin
                if (take) begin
                    // LSB arrives first, so shift new bytes in from the top
                    sh_d  = {bus.rx_data, sh_q[31:8]};
                    idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ bus.rx_data;
`endif
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                mem_we  = 1'b1;
                addr_d  = addr_q + ADDR_W'(1);
                rem_d   = rem_q - 8'd1;
                if (words_q != WORDS_MAX) begin
                    words_d = words_q + (ADDR_W+1)'(1);
                end
                state_d = (rem_q == 8'd1) ? S_END : S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (take) begin
                    if (bus.rx_data != xor_q) begin
                        err_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                hold_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            sh_q    <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            words_q <= '0;
            hold_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            err_q   <= 1'b0;
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            words_q <= words_d;
            hold_q  <= hold_d;
`ifdef LOADER_CHECKSUM_EN
            err_q   <= err_d;
            xor_q   <= xor_d;
`endif
        end
    end

    assign bus.rx_ready = rx_ready;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = sh_q;
    assign bus.mem_we   = mem_we;
    assign bus.mem_sel  = {4{mem_we}};
    assign bus.cpu_hold = hold_q;
    assign bus.done     = done;
    assign bus.words    = words_q;
`ifdef LOADER_CHECKSUM_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: frames push expected writes/done results, a monitor checks them.
module tb_ram_loader;
    localparam int ADDR_W = 5;
`ifdef LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_loader_if #(.ADDR_W(ADDR_W)) lif ();
    ram_loader #(.ADDR_W(ADDR_W), .HEADER(8'hA5)) dut (.clk(clk), .rst(rst), .bus(lif));

    typedef struct packed { logic [ADDR_W-1:0] a; logic [31:0] d; } wr_t;
    typedef struct packed { logic err; logic [ADDR_W:0] words; logic [15:0] hold; } dn_t;

    wr_t        exp_w[$];
    dn_t        exp_d[$];
    logic [7:0] fb[$];
    int         vec  = 0;
    int         errs = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rx_ready"}, 64'(lif.rx_ready), 1);
        chk({tag, "_mem_addr"}, 64'(lif.mem_addr), 0);
        chk({tag, "_mem_din"},  64'(lif.mem_din),  0);
        chk({tag, "_mem_we"},   64'(lif.mem_we),   0);
        chk({tag, "_mem_sel"},  64'(lif.mem_sel),  0);
        chk({tag, "_cpu_hold"}, 64'(lif.cpu_hold), 0);
        chk({tag, "_done"},     64'(lif.done),     0);
        chk({tag, "_err"},      64'(lif.err),      0);
        chk({tag, "_words"},    64'(lif.words),    0);
    endtask

    // Called just after a posedge; returns just after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        lif.rx_valid = 1'b1;
        lif.rx_data  = b;
        while (lif.rx_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("rx_ready_timeout", 64'(lif.rx_ready), 1);
        @(posedge clk); #1;
        lif.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] n, input logic [7:0] cks);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(n);
        foreach (fb[i]) send_byte(fb[i]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(cks);
`else
        if (cks == 8'h00) lif.rx_data = 8'h00;
`endif
    endtask

    // Monitor: compares every write and done pulse against the queues
    initial begin
        wr_t  w;
        dn_t  e;
        logic prev_we  = 1'b0;
        logic after_dn = 1'b0;
        int   hold_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_we  = 1'b0;
                after_dn = 1'b0;
                hold_cnt = 0;
            end else begin
                if (after_dn) begin
                    chk("hold_fall", 64'(lif.cpu_hold), 0);
                    chk("done_width", 64'(lif.done), 0);
                    after_dn = 1'b0;
                end
                if (lif.cpu_hold) hold_cnt++;
                if (lif.mem_we) begin
                    if (prev_we) chk("we_width", 64'(prev_we), 0);
                    chk("mem_sel_we", 64'(lif.mem_sel), 64'h f);
                    if (exp_w.size() == 0) begin
                        chk("unexpected_we", 64'(lif.mem_we), 0);
                    end else begin
                        w = exp_w.pop_front();
                        chk("mem_addr", 64'(lif.mem_addr), 64'(w.a));
                        chk("mem_din",  64'(lif.mem_din),  64'(w.d));
                    end
                end else begin
                    chk("mem_sel_idle", 64'(lif.mem_sel), 0);
                end
                prev_we = lif.mem_we;
                if (lif.done) begin
                    if (exp_d.size() == 0) begin
                        chk("unexpected_done", 64'(lif.done), 0);
                    end else begin
                        e = exp_d.pop_front();
                        chk("done_err",   64'(lif.err),   64'(e.err));
                        chk("done_words", 64'(lif.words), 64'(e.words));
                        chk("hold_len",   64'(hold_cnt),  64'(e.hold));
                    end
                    hold_cnt = 0;
                    after_dn = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [7:0] x;
        int         n;
        lif.rx_valid = 1'b0;
        lif.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single word at address 3
        exp_w.push_back('{a: 5'd3, d: 32'h12345678});
        exp_d.push_back('{err: 1'b0, words: 6'd1, hold: 16'(3 + CK + 5)});
        fb = '{8'h78, 8'h56, 8'h34, 8'h12};
        send_frame(8'h03, 8'h01, 8'h08);

        // Address wrap 31 -> 0 -> 1, good checksum
        exp_w.push_back('{a: 5'd31, d: 32'h04030201});
        exp_w.push_back('{a: 5'd0,  d: 32'h08070605});
        exp_w.push_back('{a: 5'd1,  d: 32'h0C0B0A09});
        exp_d.push_back('{err: 1'b0, words: 6'd3, hold: 16'(3 + CK + 15)});
        fb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
               8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        send_frame(8'h1F, 8'h03, 8'h0C);

        // Same frame, corrupted checksum: data still written
        exp_w.push_back('{a: 5'd31, d: 32'h04030201});
        exp_w.push_back('{a: 5'd0,  d: 32'h08070605});
        exp_w.push_back('{a: 5'd1,  d: 32'h0C0B0A09});
        exp_d.push_back('{err: 1'(CK), words: 6'd3, hold: 16'(3 + CK + 15)});
        send_frame(8'h1F, 8'h03, 8'h0D);
        repeat (2) @(posedge clk);
        #1;
        chk("err_sticky", 64'(lif.err), 64'(CK));

        // Empty frame; HEADER clears err
        exp_d.push_back('{err: 1'b0, words: 6'd0, hold: 16'(3 + CK)});
        send_byte(8'hA5);
        chk("err_clear", 64'(lif.err), 0);
        chk("hold_rise", 64'(lif.cpu_hold), 1);
        send_byte(8'h05);
        send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        repeat (2) @(posedge clk);
        #1;

        // Stray IDLE bytes, then frame whose data contains the HEADER value
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        chk("stray_hold", 64'(lif.cpu_hold), 0);
        exp_w.push_back('{a: 5'd7, d: 32'h332211A5});
        exp_w.push_back('{a: 5'd8, d: 32'h77665544});
        exp_d.push_back('{err: 1'b0, words: 6'd2, hold: 16'(3 + CK + 10)});
        fb = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        send_frame(8'h07, 8'h02, 8'hA5);

        // Reset mid-word aborts the frame
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b0;
        #2;
        chk_reset("abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_w.push_back('{a: 5'd2, d: 32'hEFBEADDE});
        exp_d.push_back('{err: 1'b0, words: 6'd1, hold: 16'(3 + CK + 5)});
        fb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(8'h02, 8'h01, 8'h22);

        // 33 words from address 0: word 32 overwrites address 0, words saturates
        fb = {};
        x  = 8'h00;
        for (int i = 0; i < 132; i++) begin
            fb.push_back(8'(i));
            x = x ^ 8'(i);
        end
        for (int k = 0; k < 33; k++) begin
            exp_w.push_back('{a: 5'(k), d: {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}});
        end
        exp_d.push_back('{err: 1'b0, words: 6'd32, hold: 16'(3 + CK + 165)});
        send_frame(8'h00, 8'd33, x);

        n = 0;
        while ((exp_w.size() != 0 || exp_d.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("pending_writes", 64'(exp_w.size()), 0);
        chk("pending_done",   64'(exp_d.size()), 0);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
